// File: rtl/conv_decoder_bs.sv
// conv_decoder_bs
// Hard-decision tail-biting Viterbi decoder, rate 1/3, K=7 (64 states).
// Pops one coded triple per information bit, runs 64 ACS units per step and
// stores one 64-bit survivor word per step. It then traces back from the
// lowest-metric end state and emits the meta byte followed by the data bytes.
//
// Ports:
//   clk, reset                 rising-edge clock, async active-low reset
//   blk_ready/blk_meta         show-ahead meta FIFO (bit0 = large block)
//   blk_meta_rdreq             registered 1-cycle pop of blk_meta
//   sym_empty/sym_data         show-ahead symbol FIFO, triple {d0,d1,d2}
//   sym_rdreq                  pop, ACS state gated by !sym_empty
//   dec_meta/dec_meta_wrreq    {tail[7:2],1'b0,size}, gated by !dec_meta_full
//   dec_data/dec_data_wrreq    decoded byte (bit0 earliest), gated by !dec_data_full
//   busy                       high outside IDLE
//   decode_done                1-cycle pulse after the last byte
//   best_metric                winning path metric, held until the next block
// The FIFO strobes are the registered FSM state ANDed with the live
// empty/full flag. This gating keeps a strobe from firing in a cycle
// where its flag is set.
module conv_decoder_bs #(
    parameter int LARGE_LEN = 6144,
    parameter int SMALL_LEN = 1056,
    parameter int PM_W      = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            blk_ready,
    input  logic [7:0]      blk_meta,
    output logic            blk_meta_rdreq,
    input  logic            sym_empty,
    input  logic [2:0]      sym_data,
    output logic            sym_rdreq,
    output logic [7:0]      dec_meta,
    output logic            dec_meta_wrreq,
    input  logic            dec_meta_full,
    output logic [7:0]      dec_data,
    output logic            dec_data_wrreq,
    input  logic            dec_data_full,
    output logic            busy,
    output logic            decode_done,
    output logic [PM_W-1:0] best_metric
);

    localparam int T_W = $clog2(LARGE_LEN);
    localparam int B_W = $clog2(LARGE_LEN / 8);
    localparam int NST = 64;

    typedef enum logic [2:0] {
        ST_IDLE, ST_ACS, ST_SELECT, ST_TRACE, ST_EMIT_META, ST_EMIT_DATA, ST_DONE
    } state_t;

    state_t            state_r, state_next_s;
    logic              size_r;
    logic [T_W-1:0]    t_r;
    logic [PM_W-1:0]   pm_r      [NST];
    logic [PM_W-1:0]   pm_next_s [NST];
    logic [NST-1:0]    dec_word_s;
    logic [5:0]        n_r, best_r, best_s;
    logic [PM_W-1:0]   best_pm_s, best_metric_r;
    logic [B_W-1:0]    byte_idx_r, byte_next_s, bytes_last_s;
    logic [T_W-1:0]    len_last_s, bit_base_s;
    logic [7:0]        dec_meta_r, dec_data_r;
    logic              blk_meta_rdreq_r, busy_r, decode_done_r;
    logic [NST-1:0]    surv_mem [LARGE_LEN];
    logic [NST-1:0]    surv_rd_s;
    logic [LARGE_LEN-1:0] dec_bits_r;
    logic              accept_s, acs_step_s, acs_last_s, trace_last_s;
    logic              meta_wr_s, data_wr_s, data_last_s, surv_bit_s;
    logic              meta_unused_s;

    // Expected coded triple {d0,d1,d2} for predecessor state s and input bit u.
    function automatic logic [2:0] enc_sym(input logic [5:0] s, input logic u);
        enc_sym = {u ^ s[4] ^ s[3] ^ s[1] ^ s[0],
                   u ^ s[5] ^ s[4] ^ s[3] ^ s[0],
                   u ^ s[5] ^ s[4] ^ s[2] ^ s[0]};
    endfunction

    // Population count of a 3-bit difference word (branch metric 0..3).
    function automatic logic [1:0] popcnt3(input logic [2:0] v);
        popcnt3 = {1'b0, v[0]} + {1'b0, v[1]} + {1'b0, v[2]};
    endfunction

    // One add-compare-select: returns {decision x, new metric} for state n.
    function automatic logic [PM_W:0] acs_unit(input logic [PM_W-1:0] pm0,
                                               input logic [PM_W-1:0] pm1,
                                               input logic [5:0]      n,
                                               input logic [2:0]      sym);
        logic [PM_W-1:0] c0, c1, diff;
        c0   = pm0 + {{(PM_W-2){1'b0}}, popcnt3(sym ^ enc_sym({n[4:0], 1'b0}, n[5]))};
        c1   = pm1 + {{(PM_W-2){1'b0}}, popcnt3(sym ^ enc_sym({n[4:0], 1'b1}, n[5]))};
        diff = c1 - c0;
        // MSB of the modulo difference means c1 < c0; ties keep x=0.
        acs_unit = diff[PM_W-1] ? {1'b1, c1} : {1'b0, c0};
    endfunction

    assign meta_unused_s = ^blk_meta[7:1];
    assign len_last_s    = size_r ? T_W'(LARGE_LEN - 1) : T_W'(SMALL_LEN - 1);
    assign bytes_last_s  = size_r ? B_W'(LARGE_LEN / 8 - 1) : B_W'(SMALL_LEN / 8 - 1);
    assign accept_s      = (state_r == ST_IDLE) && blk_ready;
    assign acs_step_s    = (state_r == ST_ACS) && !sym_empty;
    assign acs_last_s    = acs_step_s && (t_r == len_last_s);
    assign trace_last_s  = (state_r == ST_TRACE) && (t_r == '0);
    assign meta_wr_s     = (state_r == ST_EMIT_META) && !dec_meta_full;
    assign data_wr_s     = (state_r == ST_EMIT_DATA) && !dec_data_full;
    assign data_last_s   = data_wr_s && (byte_idx_r == bytes_last_s);
    assign byte_next_s   = byte_idx_r + B_W'(1);
    assign bit_base_s    = T_W'({byte_next_s, 3'b000});
    assign surv_rd_s     = surv_mem[t_r];
    assign surv_bit_s    = surv_rd_s[n_r];

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_r <= ST_IDLE;
        else        state_r <= state_next_s;
    end

    // FSM next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE:      if (accept_s)     state_next_s = ST_ACS;       else state_next_s = state_r;
            ST_ACS:       if (acs_last_s)   state_next_s = ST_SELECT;    else state_next_s = state_r;
            ST_SELECT:                      state_next_s = ST_TRACE;
            ST_TRACE:     if (trace_last_s) state_next_s = ST_EMIT_META; else state_next_s = state_r;
            ST_EMIT_META: if (meta_wr_s)    state_next_s = ST_EMIT_DATA; else state_next_s = state_r;
            ST_EMIT_DATA: if (data_last_s)  state_next_s = ST_DONE;      else state_next_s = state_r;
            ST_DONE:                        state_next_s = ST_IDLE;
            default:                        state_next_s = ST_IDLE;
        endcase
    end

    // 64 parallel ACS units; predecessors of n are 2*(n mod 32) + x.
    always_comb begin
        dec_word_s = '0;
        for (int n = 0; n < NST; n++) begin
            {dec_word_s[n], pm_next_s[n]} = acs_unit(pm_r[(2 * n) % NST],
                                                     pm_r[(2 * n) % NST + 1],
                                                     6'(n), sym_data);
        end
    end

    // Minimum-metric search, modulo compare, lowest index wins ties.
    always_comb begin
        logic [PM_W-1:0] diff;
        best_s    = '0;
        best_pm_s = pm_r[0];
        diff      = '0;
        for (int i = 1; i < NST; i++) begin
            diff = pm_r[i] - best_pm_s;
            if (diff[PM_W-1]) begin
                best_s    = 6'(i);
                best_pm_s = pm_r[i];
            end else begin
                best_s    = best_s;
                best_pm_s = best_pm_s;
            end
        end
    end

    // Path metrics, step counter, traceback state and winner bookkeeping.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NST; i++) pm_r[i] <= '0;
            t_r           <= '0;
            n_r           <= '0;
            best_r        <= '0;
            best_metric_r <= '0;
            size_r        <= 1'b0;
        end else if (accept_s) begin
            // Tail-biting: the start state is unknown, so all metrics start equal.
            for (int i = 0; i < NST; i++) pm_r[i] <= '0;
            t_r    <= '0;
            size_r <= blk_meta[0];
        end else if (acs_step_s) begin
            for (int i = 0; i < NST; i++) pm_r[i] <= pm_next_s[i];
            // The last step leaves t at L-1, which is where traceback begins.
            if (!acs_last_s) t_r <= t_r + T_W'(1);
        end else if (state_r == ST_SELECT) begin
            n_r           <= best_s;
            best_r        <= best_s;
            best_metric_r <= best_pm_s;
        end else if (state_r == ST_TRACE) begin
            n_r <= {n_r[4:0], surv_bit_s};
            if (!trace_last_s) t_r <= t_r - T_W'(1);
        end
    end

    // Survivor RAM and decoded-bit buffer; always written before being read.
    always_ff @(posedge clk) begin
        if (acs_step_s) surv_mem[t_r] <= dec_word_s;
        if (state_r == ST_TRACE) dec_bits_r[t_r] <= n_r[5];
    end

    // Registered outputs and the emit byte pointer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            blk_meta_rdreq_r <= 1'b0;
            busy_r           <= 1'b0;
            decode_done_r    <= 1'b0;
            dec_meta_r       <= 8'h00;
            dec_data_r       <= 8'h00;
            byte_idx_r       <= '0;
        end else begin
            blk_meta_rdreq_r <= accept_s;
            busy_r           <= (state_next_s != ST_IDLE);
            decode_done_r    <= (state_r == ST_DONE);
            if (trace_last_s) dec_meta_r <= {best_r, 1'b0, size_r};
            if (meta_wr_s) begin
                byte_idx_r <= '0;
                dec_data_r <= dec_bits_r[7:0];
            end else if (data_wr_s && !data_last_s) begin
                byte_idx_r <= byte_next_s;
                dec_data_r <= dec_bits_r[bit_base_s +: 8];
            end
        end
    end

    assign blk_meta_rdreq = blk_meta_rdreq_r;
    assign sym_rdreq      = acs_step_s;
    assign dec_meta       = dec_meta_r;
    assign dec_meta_wrreq = meta_wr_s;
    assign dec_data       = dec_data_r;
    assign dec_data_wrreq = data_wr_s;
    assign busy           = busy_r;
    assign decode_done    = decode_done_r;
    assign best_metric    = best_metric_r;

endmodule

// File: tb/tb_conv_decoder_bs.sv
// Testbench for conv_decoder_bs: encodes blocks with a circular convolution
// model, feeds the triples through a modelled show-ahead FIFO and compares
// the decoded bytes, meta byte, metric and timing with values computed from
// the original bits.
module tb_conv_decoder_bs;

    localparam int LARGE_LEN = 6144;
    localparam int SMALL_LEN = 1056;
    localparam int PM_W      = 8;

    logic            clk = 1'b0;
    logic            reset;
    logic            blk_ready;
    logic [7:0]      blk_meta;
    logic            blk_meta_rdreq;
    logic            sym_empty;
    logic [2:0]      sym_data;
    logic            sym_rdreq;
    logic [7:0]      dec_meta;
    logic            dec_meta_wrreq;
    logic            dec_meta_full;
    logic [7:0]      dec_data;
    logic            dec_data_wrreq;
    logic            dec_data_full;
    logic            busy;
    logic            decode_done;
    logic [PM_W-1:0] best_metric;

    conv_decoder_bs #(.LARGE_LEN(LARGE_LEN), .SMALL_LEN(SMALL_LEN), .PM_W(PM_W)) dut (
        .clk(clk), .reset(reset),
        .blk_ready(blk_ready), .blk_meta(blk_meta), .blk_meta_rdreq(blk_meta_rdreq),
        .sym_empty(sym_empty), .sym_data(sym_data), .sym_rdreq(sym_rdreq),
        .dec_meta(dec_meta), .dec_meta_wrreq(dec_meta_wrreq), .dec_meta_full(dec_meta_full),
        .dec_data(dec_data), .dec_data_wrreq(dec_data_wrreq), .dec_data_full(dec_data_full),
        .busy(busy), .decode_done(decode_done), .best_metric(best_metric)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    bit         blk_bits [LARGE_LEN];
    int         blk_len;
    bit         blk_size;
    int         exp_metric;
    logic [2:0] sym_q [$];
    logic [7:0] out_q [$];
    logic [7:0] meta_seen;
    int         meta_writes, pops, rdreq_cyc, done_cyc, strobe_cnt;
    bit         rdreq_seen, done_seen;
    int         viol_pop, viol_wr, viol_hold;
    bit         stall_en, meta_full_rand, full_trigger, hold_fired;
    int         full_hold;
    logic [7:0] hold_val;
    bit         hold_valid;

    // Generator taps per output: bit k set means the bit k steps back contributes.
    bit [6:0] taps [3] = '{7'b1101101, 7'b1001111, 7'b1010111};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic fill_bits(input int len, input bit rnd);
        for (int i = 0; i < len; i++) blk_bits[i] = rnd ? bit'($urandom_range(0, 1)) : 1'b0;
    endtask

    // One clock: drive inputs, sample at negedge, apply the FIFO pop after the edge.
    task automatic tick();
        bit do_pop;
        sym_empty     = (sym_q.size() == 0) || (stall_en && ($urandom_range(0, 1) == 1));
        sym_data      = (sym_q.size() != 0) ? sym_q[0] : 3'b000;
        dec_data_full = (full_hold > 0);
        dec_meta_full = meta_full_rand && ($urandom_range(0, 1) == 1);
        @(negedge clk);
        if (blk_meta_rdreq || sym_rdreq || dec_meta_wrreq || dec_data_wrreq || decode_done)
            strobe_cnt++;
        if (sym_rdreq) begin
            pops++;
            if (sym_empty) viol_pop++;
        end
        if (dec_data_wrreq) begin
            if (dec_data_full) viol_wr++;
            else out_q.push_back(dec_data);
        end
        if (dec_meta_wrreq) begin
            if (dec_meta_full) viol_wr++;
            else begin
                meta_writes++;
                meta_seen = dec_meta;
            end
        end
        if (dec_data_full) begin
            if (hold_valid && (dec_data !== hold_val)) viol_hold++;
            hold_val   = dec_data;
            hold_valid = 1'b1;
        end else begin
            hold_valid = 1'b0;
        end
        if (blk_meta_rdreq && !rdreq_seen) begin
            rdreq_seen = 1'b1;
            rdreq_cyc  = cyc;
        end
        if (decode_done) begin
            done_seen = 1'b1;
            done_cyc  = cyc;
        end
        if (full_hold > 0) full_hold--;
        if (full_trigger && (out_q.size() == 40)) begin
            full_hold    = 20;
            full_trigger = 1'b0;
            hold_fired   = 1'b1;
        end
        do_pop = sym_rdreq && !sym_empty;
        @(posedge clk);
        cyc++;
        #1;
        if (do_pop) void'(sym_q.pop_front());
    endtask

    // Encode the current bits (circular convolution), flip a bit of chosen triples, raise blk_ready.
    task automatic prep_block(input int len, input bit size, input int nflips);
        logic [2:0] tri_v;
        bit acc;
        blk_len    = len;
        blk_size   = size;
        exp_metric = nflips;
        sym_q.delete();
        out_q.delete();
        for (int t = 0; t < len; t++) begin
            for (int j = 0; j < 3; j++) begin
                acc = 1'b0;
                for (int k = 0; k < 7; k++)
                    if (taps[j][k]) acc ^= blk_bits[(t - k + len) % len];
                tri_v[2 - j] = acc;
            end
            if ((nflips == 3) && ((t == 10) || (t == 300) || (t == 900)))
                tri_v[$urandom_range(0, 2)] ^= 1'b1;
            sym_q.push_back(tri_v);
        end
        meta_writes = 0; pops = 0; strobe_cnt = 0;
        rdreq_seen = 1'b0; done_seen = 1'b0;
        viol_pop = 0; viol_wr = 0; viol_hold = 0; hold_valid = 1'b0;
        meta_seen = 8'h00;
        blk_meta  = 8'($urandom);
        blk_meta[0] = size;
        blk_ready = 1'b1;
    endtask

    // Run until decode_done (bounded) and compare everything against the original bits.
    task automatic finish_block(input string tag, input bit chk_latency);
        int n;
        int bad;
        logic [7:0] exp_byte, exp_meta;
        n = 0;
        while (!done_seen && (n < 4 * blk_len + 3000)) begin
            tick();
            if (rdreq_seen) blk_ready = 1'b0;
            n++;
        end
        blk_ready = 1'b0;
        check({tag, "_done"}, 32'(done_seen), 32'd1);
        check({tag, "_nbytes"}, out_q.size(), blk_len / 8);
        bad = 0;
        for (int k = 0; k < blk_len / 8; k++) begin
            for (int i = 0; i < 8; i++) exp_byte[i] = blk_bits[8 * k + i];
            if ((k >= out_q.size()) || (out_q[k] !== exp_byte)) bad++;
        end
        check({tag, "_bad_bytes"}, bad, 0);
        if (out_q.size() > 0) begin
            for (int i = 0; i < 8; i++) exp_byte[i] = blk_bits[i];
            check({tag, "_byte0"}, 32'(out_q[0]), 32'(exp_byte));
        end
        for (int j = 0; j < 6; j++) exp_meta[7 - j] = blk_bits[blk_len - 1 - j];
        exp_meta[1] = 1'b0;
        exp_meta[0] = blk_size;
        check({tag, "_meta"}, 32'(meta_seen), 32'(exp_meta));
        check({tag, "_meta_writes"}, meta_writes, 1);
        check({tag, "_metric"}, 32'(best_metric), exp_metric);
        check({tag, "_pops"}, pops, blk_len);
        check({tag, "_violations"}, viol_pop + viol_wr + viol_hold, 0);
        check({tag, "_busy_after"}, 32'(busy), 32'd0);
        if (chk_latency)
            check({tag, "_latency"}, done_cyc - rdreq_cyc + 1, 2 * blk_len + blk_len / 8 + 4);
    endtask

    initial begin
        int n;
        reset = 1'b0; blk_ready = 1'b0; blk_meta = 8'h00;
        sym_empty = 1'b1; sym_data = 3'b000; dec_meta_full = 1'b0; dec_data_full = 1'b0;
        stall_en = 1'b0; meta_full_rand = 1'b0; full_trigger = 1'b0; hold_fired = 1'b0;
        full_hold = 0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {2'b00, blk_meta_rdreq, sym_rdreq, dec_meta, dec_meta_wrreq,
                                dec_data, dec_data_wrreq, busy, decode_done, best_metric}, 32'd0);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Small block of all zeros.
        fill_bits(SMALL_LEN, 1'b0);
        prep_block(SMALL_LEN, 1'b0, 0);
        finish_block("zero", 1'b1);

        // Random small block, error free, then the same block with three single-bit errors.
        fill_bits(SMALL_LEN, 1'b1);
        prep_block(SMALL_LEN, 1'b0, 0);
        finish_block("rand", 1'b1);
        prep_block(SMALL_LEN, 1'b0, 3);
        finish_block("flip", 1'b1);

        // Large block.
        fill_bits(LARGE_LEN, 1'b1);
        prep_block(LARGE_LEN, 1'b1, 0);
        finish_block("large", 1'b1);

        // Random symbol starvation, meta back-pressure and a 20-cycle data-full hold.
        fill_bits(SMALL_LEN, 1'b1);
        stall_en = 1'b1; meta_full_rand = 1'b1; full_trigger = 1'b1;
        prep_block(SMALL_LEN, 1'b0, 0);
        finish_block("stall", 1'b0);
        check("stall_hold_fired", 32'(hold_fired), 32'd1);
        stall_en = 1'b0; meta_full_rand = 1'b0; full_trigger = 1'b0;

        // Abort with reset at ACS step 500, then a fresh block.
        fill_bits(SMALL_LEN, 1'b1);
        prep_block(SMALL_LEN, 1'b0, 0);
        n = 0;
        while ((pops < 500) && (n < 5000)) begin
            tick();
            if (rdreq_seen) blk_ready = 1'b0;
            n++;
        end
        check("abort_step", pops, 500);
        #2;
        reset = 1'b0;
        blk_ready = 1'b0;
        #1;
        check("abort_async_outputs", {2'b00, blk_meta_rdreq, sym_rdreq, dec_meta, dec_meta_wrreq,
                                      dec_data, dec_data_wrreq, busy, decode_done, best_metric}, 32'd0);
        strobe_cnt = 0;
        repeat (5) tick();
        reset = 1'b1;
        repeat (20) tick();
        check("abort_no_strobes", strobe_cnt, 0);
        check("abort_no_more_pops", pops, 500);
        fill_bits(SMALL_LEN, 1'b1);
        prep_block(SMALL_LEN, 1'b0, 0);
        finish_block("post_rst", 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
